// File: rtl/fetch_queue.sv
// fetch_queue: an instruction fetch buffer between the PC generator / instruction
// memory and decode.
//
// Memory read data arrives exactly one cycle after a request. A single in-flight
// slot (pend / pend_pc) remembers the PC of that outstanding request. On the
// following edge {pend_pc, InstrRd} is pushed into a DEPTH-entry circular queue.
// Decode sees the head entry show-ahead.
//
// Flow control uses credits. FetchStall asserts whenever the occupied entries plus
// the in-flight request could fill the queue. A push therefore always finds a free
// slot, and no entry is ever dropped.
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   rst         synchronous active-low reset; overrides every other input
//   FetchPC     PC presented to instruction memory this cycle
//   FetchValid  fetch request at FetchPC this cycle
//   InstrRd     instruction memory data, valid one cycle after an accepted request
//   Redirect    taken branch/jump; flushes queued and in-flight fetches
//   DecReady    decode consumes the head entry this cycle
//   FetchStall  PC generator must hold its PC
//   DecValid    head entry is valid
//   DecInstr    head instruction (NOP when empty)
//   DecPC       head PC (0 when empty)
//   DecPCPlus4  DecPC + 4
//   Count       number of occupied entries
module fetch_queue #(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [D_WIDTH-1:0]       FetchPC,
    input  logic                     FetchValid,
    input  logic [D_WIDTH-1:0]       InstrRd,
    input  logic                     Redirect,
    input  logic                     DecReady,
    output logic                     FetchStall,
    output logic                     DecValid,
    output logic [D_WIDTH-1:0]       DecInstr,
    output logic [D_WIDTH-1:0]       DecPC,
    output logic [D_WIDTH-1:0]       DecPCPlus4,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [D_WIDTH-1:0] instr_mem [DEPTH];
    logic [D_WIDTH-1:0] pc_mem    [DEPTH];

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic               pend;
    logic [D_WIDTH-1:0] pend_pc;

    logic [CW:0]        credits;
    logic               accept;
    logic               push;
    logic               pop;

    // The stall is decoded from registered state only, so it has no path from the
    // request or redirect inputs.
    assign credits    = {1'b0, count} + {{CW{1'b0}}, pend};
    assign FetchStall = (credits >= (CW+1)'(DEPTH));

    assign accept = FetchValid & ~FetchStall & ~Redirect;
    assign push   = pend & ~Redirect;
    assign pop    = DecValid & DecReady & ~Redirect;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (Redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pend  <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            // A push always retires the in-flight slot. A new accepted request
            // refills it in the same cycle, which allows back-to-back fetches.
            pend  <= accept;
            if (accept) begin
                pend_pc <= FetchPC;
            end
        end
    end

    // Storage needs no reset. Its contents are only visible while count != 0.
    always_ff @(posedge CLK) begin
        if (rst && push) begin
            instr_mem[tail] <= InstrRd;
            pc_mem[tail]    <= pend_pc;
        end
    end

    assign DecValid   = (count != '0);
    assign DecInstr   = DecValid ? instr_mem[head] : D_WIDTH'(32'h0000_0013);
    assign DecPC      = DecValid ? pc_mem[head] : '0;
    assign DecPCPlus4 = DecPC + D_WIDTH'(4);
    assign Count      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue.
//
// The stimulus process owns a queue-level reference model: entry list, in-flight
// flag and PC. Each cycle it checks Count, DecValid and FetchStall against that
// model. Every entry the model pushes is also appended to a scoreboard queue.
// A separate monitor pops the scoreboard whenever the design hands an entry to
// decode, and compares the head PC and instruction.
module tb_fetch_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] FetchPC = '0;
    logic          FetchValid = 1'b0;
    logic [DW-1:0] InstrRd = '0;
    logic          Redirect = 1'b0;
    logic          DecReady = 1'b0;
    logic          FetchStall;
    logic          DecValid;
    logic [DW-1:0] DecInstr;
    logic [DW-1:0] DecPC;
    logic [DW-1:0] DecPCPlus4;
    logic [$clog2(DEPTH):0] Count;

    fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .FetchPC    (FetchPC),
        .FetchValid (FetchValid),
        .InstrRd    (InstrRd),
        .Redirect   (Redirect),
        .DecReady   (DecReady),
        .FetchStall (FetchStall),
        .DecValid   (DecValid),
        .DecInstr   (DecInstr),
        .DecPC      (DecPC),
        .DecPCPlus4 (DecPCPlus4),
        .Count      (Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    ent_t        exp_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] cur_pc;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    bit          started = 1'b0;

    bit          r_fv, r_redir, r_ready, r_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Called on a falling edge. It checks the state left by the previous rising
    // edge, drives the inputs for the next edge, and advances the model.
    task automatic cycle(input bit fv, input bit redir, input bit ready, input bit rstv,
                         input logic [31:0] instr, input logic [31:0] tgt);
        int   sz;
        bit   stall, acc, psh, pp;
        ent_t e;
        sz    = mq.size();
        stall = (sz + int'(m_pend)) >= DEPTH;
        chk("count", 64'(Count), 64'(sz));
        chk("dec_valid", 64'(DecValid), 64'(sz != 0));
        chk("fetch_stall", 64'(FetchStall), 64'(stall));
        if (sz == 0) begin
            chk("idle_instr", 64'(DecInstr), 64'h13);
            chk("idle_pc", 64'(DecPC), 64'h0);
        end else begin
            chk("pc_plus4", 64'(DecPCPlus4), 64'(mq[0].pc + 32'd4));
        end

        FetchValid = fv;
        Redirect   = redir;
        DecReady   = ready;
        rst        = rstv;
        FetchPC    = cur_pc;
        InstrRd    = instr;

        acc = rstv && fv && !stall && !redir;
        psh = rstv && m_pend && !redir;
        pp  = rstv && !redir && ready && (sz != 0);
        if (!rstv || redir) begin
            mq.delete();
            exp_q.delete();
            m_pend = 1'b0;
            if (!rstv) m_pend_pc = '0;
            else cur_pc = tgt;
        end else begin
            if (pp) void'(mq.pop_front());
            if (psh) begin
                e.pc    = m_pend_pc;
                e.instr = instr;
                mq.push_back(e);
                exp_q.push_back(e);
            end
            m_pend = acc;
            if (acc) begin
                m_pend_pc = cur_pc;
                cur_pc    = cur_pc + 32'd4;
            end
        end
        @(negedge CLK);
    endtask

    // Monitor: whenever decode takes the head this cycle, it must match the
    // oldest outstanding expected entry.
    always @(negedge CLK) begin
        #2;
        if (started && rst && !Redirect && DecReady && DecValid) begin
            if (exp_q.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("head_pc", 64'(DecPC), 64'(e.pc));
                chk("head_instr", 64'(DecInstr), 64'(e.instr));
            end
        end
    end

    initial begin
        m_pend    = 1'b0;
        m_pend_pc = '0;
        cur_pc    = '0;
        rst       = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        started = 1'b1;

        // Reset held: idle outputs.
        cycle(1, 1, 1, 0, 32'h0, 32'h0);
        cycle(0, 0, 0, 1, 32'h0, 32'h0);

        // Single fetch at 0x100 with minimum latency.
        cur_pc = 32'h100;
        cycle(1, 0, 0, 1, $urandom, 32'h0);
        cycle(0, 0, 0, 1, 32'h0050_0093, 32'h0);
        cycle(0, 0, 1, 1, $urandom, 32'h0);
        cycle(0, 0, 0, 1, $urandom, 32'h0);

        // Fill with decode blocked, then drain in order.
        cycle(0, 1, 0, 1, $urandom, 32'h0);
        repeat (8) cycle(1, 0, 0, 1, $urandom, 32'h0);
        repeat (6) cycle(0, 0, 1, 1, $urandom, 32'h0);

        // Streaming.
        repeat (12) cycle(1, 0, 1, 1, $urandom, 32'h0);
        repeat (3) cycle(0, 0, 1, 1, $urandom, 32'h0);

        // Redirect with three queued entries and one in flight.
        repeat (4) cycle(1, 0, 0, 1, $urandom, 32'h0);
        cycle(1, 1, 0, 1, $urandom, 32'h200);
        cycle(1, 0, 0, 1, $urandom, 32'h0);
        cycle(0, 0, 0, 1, $urandom, 32'h0);
        repeat (3) cycle(0, 0, 1, 1, $urandom, 32'h0);

        // Pointer wrap under mixed push/pop.
        for (int i = 0; i < 20; i++) cycle(1, 0, (i % 3) != 0, 1, $urandom, 32'h0);
        repeat (5) cycle(0, 0, 1, 1, $urandom, 32'h0);

        // Reset mid-stream with two queued entries.
        repeat (3) cycle(1, 0, 0, 1, $urandom, 32'h0);
        cycle(1, 1, 1, 0, $urandom, 32'h0);
        repeat (4) cycle(0, 0, 1, 1, $urandom, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r_fv    = ($urandom_range(0, 3) != 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_ready = ($urandom_range(0, 2) != 0);
            r_rst   = ($urandom_range(0, 99) != 0);
            cycle(r_fv, r_redir, r_ready, r_rst, $urandom, $urandom & 32'hFFFF_FFFC);
        end
        repeat (6) cycle(0, 0, 1, 1, $urandom, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
